// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared constants and cycle-count derivations for input_conditioner
package input_cond_pkg;

    localparam logic KEY_IDLE = 1'b1;
    localparam logic SW_IDLE  = 1'b0;

    function automatic int db_cycles(input int clk_hz, input int debounce_ms);
        return clk_hz / 1000 * debounce_ms;
    endfunction

    function automatic int lp_cycles(input int clk_hz, input int long_press_ms);
        return clk_hz / 1000 * long_press_ms;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - 2-flop synchronizer plus stable-time debouncer for one input bit
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int   DB_CYC = 10,
    parameter logic IDLE   = SW_IDLE
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic load
);

    localparam int              CW       = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYC - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // High on the edge where level adopts sync; lets the parent register strobes in lockstep.
    assign load = (sync != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= IDLE;
            sync  <= IDLE;
            level <= IDLE;
            cnt   <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == level) begin
                cnt <= '0;
            end else if (load) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced keys/switches with press, long-press and switch-change strobes
// Long-press hold counters are built only when INPUT_COND_LONG_PRESS_EN is defined.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int LONG_PRESS_MS = 1000,
    parameter int N_BTN         = 2,
    parameter int N_SW          = 10
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [N_BTN-1:0] key_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] button_external_connection_export,
    output logic [N_SW-1:0]  switch_external_connection_export,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] long_press,
    output logic             sw_changed
);

    localparam int DB_CYC = db_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int LP_CYC = lp_cycles(CLK_HZ, LONG_PRESS_MS);

    logic [N_BTN-1:0] key_level;
    logic [N_BTN-1:0] key_load;
    logic [N_SW-1:0]  sw_level;
    logic [N_SW-1:0]  sw_load;

    for (genvar i = 0; i < N_BTN; i++) begin : g_key
        debounce_bit #(
            .DB_CYC (DB_CYC),
            .IDLE   (KEY_IDLE)
        ) u_key (
            .clk   (clk_clk),
            .rst   (reset_reset),
            .raw   (key_raw[i]),
            .level (key_level[i]),
            .load  (key_load[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .DB_CYC (DB_CYC),
            .IDLE   (SW_IDLE)
        ) u_sw (
            .clk   (clk_clk),
            .rst   (reset_reset),
            .raw   (sw_raw[i]),
            .level (sw_level[i]),
            .load  (sw_load[i])
        );
    end

    assign button_external_connection_export = key_level;
    assign switch_external_connection_export = sw_level;

    // A key load while its level is 1 is a press; loads while at 0 are releases.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            press_pulse <= '0;
            sw_changed  <= 1'b0;
        end else begin
            press_pulse <= key_load & key_level;
            sw_changed  <= |sw_load;
        end
    end

`ifdef INPUT_COND_LONG_PRESS_EN
    localparam int            HW        = $clog2(LP_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LP_CYC - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LP_CYC);

    logic [HW-1:0] hold_cnt [N_BTN];

    // Counter parks at LP_CYC while held, so each hold fires exactly once.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            long_press <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                long_press[i] <= 1'b0;
                if (key_load[i] && key_level[i]) begin
                    hold_cnt[i] <= '0;
                end else if (!key_level[i]) begin
                    if (hold_cnt[i] != HOLD_SAT) begin
                        hold_cnt[i] <= hold_cnt[i] + HW'(1);
                    end
                    long_press[i] <= (hold_cnt[i] == HOLD_LAST);
                end else begin
                    hold_cnt[i] <= '0;
                end
            end
        end
    end
`else
    logic unused_lp_cfg;

    assign unused_lp_cfg = (LP_CYC < 1);
    assign long_press    = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - scoreboard bench for input_conditioner against a run-length reference model
module tb_input_conditioner;

    localparam int CLK_HZ        = 1000;
    localparam int DEBOUNCE_MS   = 10;
    localparam int LONG_PRESS_MS = 50;
    localparam int N_BTN         = 2;
    localparam int N_SW          = 10;
    localparam int NB            = N_BTN + N_SW;
    localparam int DB            = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LP            = CLK_HZ / 1000 * LONG_PRESS_MS;
`ifdef INPUT_COND_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] key_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_out;
    logic [N_SW-1:0]  sw_out;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] long_press;
    logic             sw_changed;

    input_conditioner #(
        .CLK_HZ        (CLK_HZ),
        .DEBOUNCE_MS   (DEBOUNCE_MS),
        .LONG_PRESS_MS (LONG_PRESS_MS),
        .N_BTN         (N_BTN),
        .N_SW          (N_SW)
    ) dut (
        .clk_clk                           (clk),
        .reset_reset                       (rst),
        .key_raw                           (key_raw),
        .sw_raw                            (sw_raw),
        .button_external_connection_export (btn_out),
        .switch_external_connection_export (sw_out),
        .press_pulse                       (press_pulse),
        .long_press                        (long_press),
        .sw_changed                        (sw_changed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ev_exp = 0;
    int n_ev_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Expected strobe events; kind 0 = press, 1 = long press, 2 = switch change.
    typedef struct {
        int edge_no;
        int kind;
        int idx;
    } ev_t;

    ev_t exp_q[$];

    localparam logic [NB-1:0] IDLE_VEC = {{N_SW{1'b0}}, {N_BTN{1'b1}}};

    int            edge_no = 0;
    logic [NB-1:0] m_level, m_p1, m_p2, m_last;
    int            m_run [NB];
    int            press_edge [N_BTN];
    bit            armed [N_BTN];

    task automatic push_ev(input int kind, input int idx);
        ev_t e;
        e.edge_no = edge_no;
        e.kind    = kind;
        e.idx     = idx;
        exp_q.push_back(e);
        n_ev_exp++;
    endtask

    // Reference: a bit's debounced level flips once its twice-delayed sample has held
    // the opposite value for DB consecutive clocks.
    always @(posedge clk) begin
        logic [NB-1:0] raw_now;
        logic [NB-1:0] lvl_old;
        logic          d;
        edge_no++;
        raw_now = {sw_raw, key_raw};
        if (rst) begin
            m_level = IDLE_VEC;
            m_p1    = IDLE_VEC;
            m_p2    = IDLE_VEC;
            m_last  = IDLE_VEC;
            for (int b = 0; b < NB; b++) m_run[b] = 0;
            for (int k = 0; k < N_BTN; k++) armed[k] = 1'b0;
            exp_q.delete();
        end else begin
            lvl_old = m_level;
            for (int b = 0; b < NB; b++) begin
                d = m_p2[b];
                if (d == m_last[b]) begin
                    if (m_run[b] < 1000000) m_run[b]++;
                end else begin
                    m_run[b] = 1;
                end
                m_last[b] = d;
                if (m_run[b] >= DB && d != m_level[b]) m_level[b] = d;
            end
            m_p2 = m_p1;
            m_p1 = raw_now;
            for (int k = 0; k < N_BTN; k++) begin
                if (armed[k]) begin
                    if (lvl_old[k]) begin
                        armed[k] = 1'b0;
                    end else if (edge_no - press_edge[k] == LP) begin
                        if (LP_EN) push_ev(1, k);
                        armed[k] = 1'b0;
                    end
                end
                if (lvl_old[k] && !m_level[k]) begin
                    push_ev(0, k);
                    press_edge[k] = edge_no;
                    armed[k]      = 1'b1;
                end
            end
            if (m_level[NB-1:N_BTN] != lvl_old[NB-1:N_BTN]) push_ev(2, 0);
        end
    end

    always @(negedge clk) begin
        logic [N_BTN-1:0] ep;
        logic [N_BTN-1:0] el;
        logic             es;
        ev_t              ev;
        ep = '0;
        el = '0;
        es = 1'b0;
        while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_no) begin
            ev = exp_q.pop_front();
            case (ev.kind)
                0:       ep[ev.idx] = 1'b1;
                1:       el[ev.idx] = 1'b1;
                default: es = 1'b1;
            endcase
        end
        if (rst) begin
            check("reset_outputs", {sw_changed, long_press, press_pulse, sw_out, btn_out},
                  {1'b0, {N_BTN{1'b0}}, {N_BTN{1'b0}}, IDLE_VEC});
        end else begin
            check("levels", {sw_out, btn_out}, m_level);
            check("strobes", {sw_changed, long_press, press_pulse}, {es, el, ep});
            n_ev_seen += $countones({sw_changed, long_press, press_pulse});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int len;
        int mode;
        rst     = 1'b1;
        key_raw = '1;
        sw_raw  = '0;
        step(3);
        rst = 1'b0;
        step(5);

        // reset during a debounce count
        key_raw[1] = 1'b0;
        step(6);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        key_raw[1] = 1'b1;
        step(20);

        // clean press and release
        key_raw[0] = 1'b0;
        step(20);
        key_raw[0] = 1'b1;
        step(20);

        // bouncing key, then held
        for (int t = 0; t < 10; t++) begin
            key_raw[1] = ~key_raw[1];
            step(4);
        end
        key_raw[1] = 1'b0;
        step(30);
        key_raw[1] = 1'b1;
        step(20);

        // short switch glitch, then two switches together
        sw_raw[3] = 1'b1;
        step(9);
        sw_raw[3] = 1'b0;
        step(20);
        sw_raw[3] = 1'b1;
        sw_raw[7] = 1'b1;
        step(20);
        sw_raw = '0;
        step(20);

        // long hold, then short hold
        key_raw[0] = 1'b0;
        step(200);
        key_raw[0] = 1'b1;
        step(20);
        key_raw[0] = 1'b0;
        step(30);
        key_raw[0] = 1'b1;
        step(20);

        // inputs already active at reset release
        rst     = 1'b1;
        key_raw = 2'b10;
        sw_raw  = 10'h001;
        step(3);
        rst = 1'b0;
        step(30);
        key_raw = '1;
        sw_raw  = '0;
        step(20);

        // randomized segments: bouncing, holds, occasional reset pulses
        repeat (80) begin
            mode = $urandom_range(0, 9);
            if (mode < 4) begin
                len = $urandom_range(1, 40);
                for (int c = 0; c < len; c++) begin
                    if ($urandom_range(0, 3) == 0) key_raw ^= N_BTN'($urandom);
                    if ($urandom_range(0, 3) == 0) sw_raw ^= N_SW'($urandom);
                    step(1);
                end
            end else if (mode < 9) begin
                key_raw = N_BTN'($urandom);
                sw_raw  = N_SW'($urandom);
                step($urandom_range(5, 120));
            end else begin
                rst = 1'b1;
                step($urandom_range(1, 3));
                rst = 1'b0;
                step(1);
            end
        end

        key_raw = '1;
        sw_raw  = '0;
        step(30);
        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("event_count", 64'(n_ev_seen), 64'(n_ev_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Synchronizes and debounces the DE10-Lite push-buttons and slide switches before they reach the NIOS system's button and switch PIO inputs. It also generates single-cycle press, long-press and switch-change event strobes for the interrupt and edge-capture logic. The block sits between the top-level board pins and the NIOS system instance, in the same clock domain as the NIOS system.

## Interface
Parameters:
- CLK_HZ, 50_000_000: clock frequency in Hz.
- DEBOUNCE_MS, 10: required stable time. DB_CYC = CLK_HZ/1000*DEBOUNCE_MS, which must be ≥ 1.
- LONG_PRESS_MS, 1000: hold time for a long press. LP_CYC = CLK_HZ/1000*LONG_PRESS_MS, which must be ≥ 1.
- N_BTN, 2: number of buttons.
- N_SW, 10: number of switches.

Ports:
- clk_clk, in, 1: the single clock.
- reset_reset, in, 1: asynchronous, active-high reset.
- key_raw, in, N_BTN: raw button pins. Asynchronous, active-low (0 = pressed).
- sw_raw, in, N_SW: raw switch pins. Asynchronous.
- button_external_connection_export, out, N_BTN: debounced button level, active-low. Reset value all 1s.
- switch_external_connection_export, out, N_SW: debounced switch level. Reset value 0.
- press_pulse, out, N_BTN: one-cycle strobe on a debounced 1→0 transition. Reset value 0.
- long_press, out, N_BTN: one-cycle strobe once per hold. Reset value 0.
- sw_changed, out, 1: one-cycle strobe when any debounced switch changes. Reset value 0.

## Operation
Each input bit is processed independently:
- 2-flop synchronizer. Reset values: keys 1, switches 0.
- Stable register holding the debounced level, plus a counter of width $clog2(DB_CYC+1).
- Each edge where sync output ≠ stable: counter increments.
- When the counter reaches DB_CYC: stable takes the sync value and the counter clears.
- Any edge where sync output = stable: counter clears. Consequently, a glitch shorter than DB_CYC cycles never propagates.

Event strobes:
- press_pulse[i] asserts in the same cycle that button output bit i first reads 0.
- Release (0→1) generates no strobe.
- Long press, per button:
  - A hold counter clears on press_pulse and then increments while the button is pressed.
  - long_press[i] pulses when the counter reaches LP_CYC, i.e. exactly LP_CYC cycles after press_pulse[i].
  - The counter then saturates, so there is no auto-repeat.
  - Release clears the counter. A release before LP_CYC produces no long_press.
- sw_changed asserts in the same cycle that the switch output vector differs from its previous value. Multiple bits changing on one edge produce a single pulse.

Boundary conditions:
- Simultaneous events on different bits are fully independent.
- Reset asserted mid-count or mid-hold clears everything immediately, with no strobes.
- Inputs already active at reset release debounce normally and then strobe, e.g. a held key yields press_pulse and a high switch yields sw_changed.

## Timing
- Raw change first sampled at edge 1: sync output valid after edge 2.
- Debounced output and strobe change at edge DB_CYC+2 when the input is held stable.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Strobes are exactly one cycle wide.

## Configuration
- INPUT_COND_LONG_PRESS_EN defined: the hold counters and long_press logic are compiled in.
- Undefined: long_press is tied to 0, no hold counters are generated, and all other behaviour is identical.

## Structure
- Package input_cond_pkg holds:
  - the DB_CYC/LP_CYC derivation functions;
  - the idle-level constants KEY_IDLE=1 and SW_IDLE=0.
- Sub-module debounce_bit contains the synchronizer, counter and stable register, with the idle level as a parameter. It is instantiated N_BTN+N_SW times.
- Event and long-press logic live in the top module.

## Test plan
All scenarios use CLK_HZ=1000, DEBOUNCE_MS=10 (DB_CYC=10) and LONG_PRESS_MS=50 (LP_CYC=50).
1. Reset with key_raw=2'b11, sw_raw=0 → button output 2'b11, switch output 0, all strobes 0. Assert reset mid-count → counters clear with no strobe.
2. key_raw[0] falls before edge 1 and is held → button[0]=0 and press_pulse[0]=1 after edge 12, and press_pulse is high for one cycle only.
3. key_raw[1] toggles every 4 cycles for 40 cycles, then is held low → no output change during the bounce; one press_pulse 12 edges after the final toggle.
4. sw_raw[3] high for 9 cycles, then low → no change and no sw_changed. sw_raw[3] and sw_raw[7] rise together and are held → one sw_changed pulse, and switch output becomes 0x088.
5. key_raw[0] held for 200 cycles → long_press[0] exactly 50 cycles after press_pulse[0] and no repeat. A 30-cycle hold → no long_press. With the macro undefined → long_press stays 0.
6. key_raw pressed at reset release → press_pulse after edge 12 following deassertion.
